// File: rtl/fm_stream_pkg.sv
// Shared definitions for the feature-map producer/consumer pair: default geometry,
// streamer state encoding and the (row, col, chan) element-ordering helpers.
package fm_stream_pkg;

  localparam int H_DEF  = 16;
  localparam int W_DEF  = 8;
  localparam int F_DEF  = 16;
  localparam int DW_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic [$clog2(H_DEF)-1:0] row;
    logic [$clog2(W_DEF)-1:0] col;
    logic [$clog2(F_DEF)-1:0] chan;
  } index_t;

  // Flat element number n = r*W*F + c*F + f; element n lives at bits [n*DW +: DW].
  function automatic int unsigned elem_offset(input index_t idx, input int unsigned w,
                                              input int unsigned f);
    return int'(idx.row) * w * f + int'(idx.col) * f + int'(idx.chan);
  endfunction

endpackage

// File: rtl/fm_index_counter.sv
// Nested raster counter: channel fastest, then column, then row. `last` flags the
// final element of the map.
module fm_index_counter #(
  parameter int H = fm_stream_pkg::H_DEF,
  parameter int W = fm_stream_pkg::W_DEF,
  parameter int F = fm_stream_pkg::F_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 advance,
  output logic [$clog2(H)-1:0] row,
  output logic [$clog2(W)-1:0] col,
  output logic [$clog2(F)-1:0] chan,
  output logic                 last
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int FW = $clog2(F);

  logic row_max;
  logic col_max;
  logic chan_max;

  assign row_max  = (row  == RW'(H - 1));
  assign col_max  = (col  == CW'(W - 1));
  assign chan_max = (chan == FW'(F - 1));
  assign last     = row_max && col_max && chan_max;

  // clear wins over advance so a back-to-back capture restarts at element 0.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      chan <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      chan <= '0;
    end else if (advance) begin
      if (chan_max) begin
        chan <= '0;
        if (col_max) begin
          col <= '0;
          row <= row_max ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        chan <= chan + FW'(1);
      end
    end
  end

endmodule

// File: rtl/feature_map_streamer.sv
// Captures a whole INT16 feature map on a one-cycle pulse and streams it out in
// raster order on a valid/ready port, tagging each beat with its coordinates.
module feature_map_streamer
  import fm_stream_pkg::*;
#(
  parameter int H  = H_DEF,
  parameter int W  = W_DEF,
  parameter int F  = F_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [H*W*F*DW-1:0]         fm_data,
  input  logic                        fm_valid,
  output logic signed [DW-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(H)-1:0]        m_row,
  output logic [$clog2(W)-1:0]        m_col,
  output logic [$clog2(F)-1:0]        m_chan,
  output logic                        m_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  drop_count
);

  localparam int FRAME_W = H * W * F * DW;

  state_t             state_q;
  state_t             state_d;
  logic [FRAME_W-1:0] frame_q;
  logic               idx_last;
  logic               xfer;
  logic               last_xfer;
  logic               capture;
  logic               drop;

  assign xfer      = m_valid && m_ready;
  assign last_xfer = xfer && idx_last;
  // A pulse is accepted when idle or exactly as the final beat leaves; otherwise dropped.
  assign capture   = fm_valid && ((state_q == IDLE) || last_xfer);
  assign drop      = fm_valid && (state_q == STREAM) && !last_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fm_valid)               state_d = STREAM;
      STREAM:  if (last_xfer && !fm_valid) state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    busy    = 1'b0;
    if (state_q == STREAM) begin
      m_valid = 1'b1;
      busy    = 1'b1;
    end
  end

  // NOTE: the frame buffer is a large data store with no reset; only the control
  // state is reset, and the output mux below masks the stale contents while idle.
  always_ff @(posedge clk) begin
    if (capture)   frame_q <= fm_data;
    else if (xfer) frame_q <= frame_q >> DW;
  end

  assign m_data = m_valid ? $signed(frame_q[DW-1:0]) : '0;
  assign m_last = m_valid && idx_last;

  fm_index_counter #(
    .H (H),
    .W (W),
    .F (F)
  ) u_index (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (capture),
    .advance (xfer),
    .row     (m_row),
    .col     (m_col),
    .chan    (m_chan),
    .last    (idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= last_xfer;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_feature_map_streamer.sv
// Randomized bench for feature_map_streamer against a frame-level reference model
// (element queue plus coordinates derived arithmetically from the beat number).
module tb_feature_map_streamer;

  localparam int H       = 16;
  localparam int W       = 8;
  localparam int F       = 16;
  localparam int DW      = 16;
  localparam int NE      = H * W * F;
  localparam int FRAME_W = NE * DW;
  localparam int RW      = $clog2(H);
  localparam int CW      = $clog2(W);
  localparam int FW      = $clog2(F);

  logic                 clk;
  logic                 rst_n;
  logic [FRAME_W-1:0]   fm_data;
  logic                 fm_valid;
  logic signed [DW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [RW-1:0]        m_row;
  logic [CW-1:0]        m_col;
  logic [FW-1:0]        m_chan;
  logic                 m_last;
  logic                 busy;
  logic                 frame_done;
  logic [7:0]           drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int drops_model = 0;

  logic [DW-1:0] cur_m [NE];
  logic [DW-1:0] nxt_m [NE];

  feature_map_streamer #(.H(H), .W(W), .F(F), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fm_data    (fm_data),
    .fm_valid   (fm_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {valid, busy, frame_done, data, row, col, chan, last} for beat n.
  function automatic logic [63:0] want(input int n, input logic [DW-1:0] d, input logic fd);
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [FW-1:0] ch;
    r  = RW'(n / (W * F));
    c  = CW'((n / F) % W);
    ch = FW'(n % F);
    return {33'b0, 1'b1, 1'b1, fd, d, r, c, ch, (n == NE - 1)};
  endfunction

  function automatic logic [63:0] got_beat();
    return {33'b0, m_valid, busy, frame_done, m_data, m_row, m_col, m_chan, m_last};
  endfunction

  task automatic make_next(input int mode);
    for (int n = 0; n < NE; n++) begin
      case (mode)
        0:       nxt_m[n] = DW'(n);
        1:       nxt_m[n] = 16'h8000 ^ DW'(n);
        default: nxt_m[n] = DW'($urandom);
      endcase
    end
  endtask

  task automatic stage_next();
    for (int n = 0; n < NE; n++) fm_data[n*DW +: DW] = nxt_m[n];
  endtask

  task automatic start_frame();
    stage_next();
    @(negedge clk);
    fm_valid = 1'b1;
    m_ready  = 1'b0;
    cur_m    = nxt_m;
  endtask

  task automatic note_drop();
    fm_valid = 1'b1;
    fm_data  = {(FRAME_W/32){$urandom}};
    if (drops_model < 255) drops_model++;
  endtask

  // Receives one frame; optional drop pulses, back-to-back restart or mid-frame reset.
  task automatic drain(input int ready_pct, input int pulse_a, input int pulse_b,
                       input bit b2b, input int stop_at);
    int beat   = 0;
    int cycles = 0;
    bit done_a = 1'b0;
    bit done_b = 1'b0;
    while (beat < NE && cycles < NE * 20) begin
      @(negedge clk);
      cycles++;
      fm_valid = 1'b0;
      if (beat == stop_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame",
              {m_valid, busy, frame_done, m_data, m_row, m_col, m_chan, m_last, drop_count}, 64'd0);
        drops_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("beat", got_beat(), want(beat, cur_m[beat], 1'b0));
      m_ready = ($urandom_range(99) < ready_pct);
      if (!done_a && beat == pulse_a) begin done_a = 1'b1; note_drop(); end
      if (!done_b && beat == pulse_b) begin done_b = 1'b1; note_drop(); end
      if (b2b && beat == NE - 1 && m_ready) begin
        stage_next();
        fm_valid = 1'b1;
      end
      if (m_ready) beat++;
    end
    check("beat_count", 64'(beat), 64'(NE));
    @(negedge clk);
    fm_valid = 1'b0;
    m_ready  = 1'b0;
    if (b2b) begin
      cur_m = nxt_m;
      check("b2b_first_beat", got_beat(), want(0, cur_m[0], 1'b1));
      check("b2b_drops", 64'(drop_count), 64'(drops_model));
    end else begin
      check("frame_end", {frame_done, busy, m_valid, m_last}, 4'b1000);
      @(negedge clk);
      check("frame_done_pulse", 64'(frame_done), 64'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    fm_valid = 1'b0;
    m_ready  = 1'b0;
    fm_data  = '0;
    #12;
    check("reset_state",
          {m_valid, busy, frame_done, m_data, m_row, m_col, m_chan, m_last, drop_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    make_next(0); start_frame(); drain(100, -1, -1, 1'b0, -1);
    make_next(1); start_frame(); drain(50, -1, -1, 1'b0, -1);

    make_next(2); start_frame(); drain(100, -1, -1, 1'b0, 1000);
    make_next(2); start_frame(); drain(60, -1, -1, 1'b0, -1);

    make_next(2); start_frame(); drain(100, 5, 900, 1'b0, -1);
    check("drop_count_two", 64'(drop_count), 64'(drops_model));

    make_next(2); start_frame(); make_next(2); drain(70, -1, -1, 1'b1, -1);
    drain(100, -1, -1, 1'b0, -1);

    make_next(2); start_frame();
    repeat (300) begin
      @(negedge clk);
      m_ready = 1'b0;
      note_drop();
    end
    @(negedge clk);
    fm_valid = 1'b0;
    check("drop_count_sat", 64'(drop_count), 64'(drops_model));
    drain(100, -1, -1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
